// File: rtl/n1_core.sv
// n1_core: two-phase FETCH/EXEC core for the 16-bit n1 ISA.
// Unified program/data memory, loaded by the host while IDLE.
module n1_core #(
  parameter int DATA_W      = 16,
  parameter int NREGS       = 4,
  parameter int MEM_DEPTH   = 128,
  parameter int STACK_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        prog_we,
  input  logic [7:0]  prog_addr,
  input  logic [15:0] prog_data,
  output logic [7:0]  dbg_out,
  output logic        dbg_valid,
  output logic        halted,
  output logic        fault,
  output logic [7:0]  pc_out
);
  localparam int AW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int SIW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int MSB = DATA_W - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_HALT, S_FAULT
  } state_t;

  localparam int OP_NOP  = 0;
  localparam int OP_MOVI = 1;
  localparam int OP_STR  = 2;
  localparam int OP_ADD  = 3;
  localparam int OP_SUB  = 4;
  localparam int OP_MUL  = 5;
  localparam int OP_LDR  = 6;
  localparam int OP_OUT  = 7;
  localparam int OP_HALT = 8;
  localparam int OP_CMP  = 9;
  localparam int OP_JMP  = 10;
  localparam int OP_JNE  = 11;
  localparam int OP_JLE  = 12;
  localparam int OP_JEQ  = 13;
  localparam int OP_CALL = 14;
  localparam int OP_RET  = 15;

  state_t            state;
  logic [7:0]        pc;
  logic [15:0]       ir;
  logic [SPW-1:0]    sp;
  logic [DATA_W-1:0] regs [8];
  logic              fn, fz, fc, fv;
  logic [7:0]        stk [STACK_DEPTH];
  logic [15:0]       mem [MEM_DEPTH];

  logic [15:0]       dec;
  logic [2:0]        rd, ra, rb;
  logic [7:0]        addr;
  logic [DATA_W-1:0] va, vb, vd, mul_r;
  logic [DATA_W:0]   add_r, sub_r, cmp_r;
  logic [15:0]       mem_q;
  logic              abad;

  assign dec   = 16'd1 << ir[15:12];
  assign rd    = ir[11:9];
  assign ra    = ir[8:6];
  assign rb    = ir[5:3];
  assign addr  = ir[7:0];
  assign va    = regs[ra];
  assign vb    = regs[rb];
  assign vd    = regs[rd];
  assign add_r = {1'b0, va} + {1'b0, vb};
  assign sub_r = {1'b0, va} - {1'b0, vb};
  assign cmp_r = {1'b0, vd} - {1'b0, va};
  assign mul_r = va * vb;
  assign mem_q = mem[addr[AW-1:0]];
  assign abad  = int'(addr) >= MEM_DEPTH;

  function automatic logic rbad(input logic [2:0] i);
    return int'(i) >= NREGS;
  endfunction

  logic              bad, halt, wr_en, flg_en;
  logic              cout, ovf, push, pop;
  logic              st_en, out_en;
  logic [DATA_W-1:0] wr_val, res;
  logic [7:0]        pc_nxt;

  always_comb begin
    bad    = 1'b0;
    halt   = 1'b0;
    wr_en  = 1'b0;
    flg_en = 1'b0;
    cout   = 1'b0;
    ovf    = 1'b0;
    push   = 1'b0;
    pop    = 1'b0;
    st_en  = 1'b0;
    out_en = 1'b0;
    wr_val = '0;
    res    = '0;
    pc_nxt = pc + 8'd1;
    unique case (1'b1)
      dec[OP_NOP]: ;
      dec[OP_MOVI]: begin
        bad    = rbad(rd);
        wr_en  = 1'b1;
        wr_val = DATA_W'(addr);
      end
      dec[OP_STR]: begin
        bad   = rbad(rd) | abad;
        st_en = 1'b1;
      end
      dec[OP_ADD]: begin
        bad    = rbad(rd) | rbad(ra) | rbad(rb);
        wr_en  = 1'b1;
        flg_en = 1'b1;
        res    = add_r[MSB:0];
        wr_val = res;
        cout   = add_r[DATA_W];
        ovf    = (va[MSB] == vb[MSB]) &&
                 (add_r[MSB] != va[MSB]);
      end
      dec[OP_SUB]: begin
        bad    = rbad(rd) | rbad(ra) | rbad(rb);
        wr_en  = 1'b1;
        flg_en = 1'b1;
        res    = sub_r[MSB:0];
        wr_val = res;
        cout   = ~sub_r[DATA_W];
        ovf    = (va[MSB] != vb[MSB]) &&
                 (sub_r[MSB] != va[MSB]);
      end
      dec[OP_MUL]: begin
        bad    = rbad(rd) | rbad(ra) | rbad(rb);
        wr_en  = 1'b1;
        wr_val = mul_r;
      end
      dec[OP_LDR]: begin
        bad    = rbad(rd) | abad;
        wr_en  = 1'b1;
        wr_val = DATA_W'(mem_q);
      end
      dec[OP_OUT]: begin
        bad    = abad;
        out_en = 1'b1;
      end
      dec[OP_HALT]: halt = 1'b1;
      dec[OP_CMP]: begin
        bad    = rbad(rd) | rbad(ra);
        flg_en = 1'b1;
        res    = cmp_r[MSB:0];
        cout   = ~cmp_r[DATA_W];
        ovf    = (vd[MSB] != va[MSB]) &&
                 (cmp_r[MSB] != vd[MSB]);
      end
      dec[OP_JMP]: begin
        bad    = abad;
        pc_nxt = addr;
      end
      dec[OP_JNE]: begin
        bad = abad;
        if (!fz) pc_nxt = addr;
      end
      dec[OP_JLE]: begin
        bad = abad;
        if (fz | (fn ^ fv)) pc_nxt = addr;
      end
      dec[OP_JEQ]: begin
        bad = abad;
        if (fz) pc_nxt = addr;
      end
      dec[OP_CALL]: begin
        bad    = abad | (int'(sp) == STACK_DEPTH);
        push   = 1'b1;
        pc_nxt = addr;
      end
      dec[OP_RET]: begin
        bad    = (sp == '0);
        pop    = 1'b1;
        pc_nxt = stk[SIW'(sp - 1'b1)];
      end
      default: ;
    endcase
  end

  logic exec_ok, host_we;
  assign exec_ok = (state == S_EXEC) && !bad && !halt;
  assign host_we = (state == S_IDLE) && prog_we &&
                   (int'(prog_addr) < MEM_DEPTH);

  // carry is architectural state but no branch consumes it
  logic unused_carry;
  assign unused_carry = fc;

  always_ff @(posedge clk) begin
    if (host_we)
      mem[prog_addr[AW-1:0]] <= prog_data;
    else if (exec_ok && st_en)
      mem[addr[AW-1:0]] <= 16'(vd);
  end

  always_ff @(posedge clk) begin
    if (exec_ok && push)
      stk[SIW'(sp)] <= pc + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= '0;
      ir        <= '0;
      sp        <= '0;
      fn        <= 1'b0;
      fz        <= 1'b0;
      fc        <= 1'b0;
      fv        <= 1'b0;
      dbg_out   <= '0;
      dbg_valid <= 1'b0;
      halted    <= 1'b0;
      fault     <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      dbg_valid <= 1'b0;
      unique case (state)
        S_IDLE: if (run) state <= S_FETCH;
        S_FETCH: begin
          if (int'(pc) >= MEM_DEPTH) begin
            state <= S_FAULT;
            fault <= 1'b1;
          end else begin
            ir    <= mem[pc[AW-1:0]];
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (bad) begin
            state <= S_FAULT;
            fault <= 1'b1;
          end else if (halt) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else begin
            state <= S_FETCH;
            pc    <= pc_nxt;
            if (wr_en) regs[rd] <= wr_val;
            if (flg_en) begin
              fn <= res[MSB];
              fz <= (res == '0);
              fc <= cout;
              fv <= ovf;
            end
            if (push) sp <= sp + 1'b1;
            if (pop)  sp <= sp - 1'b1;
            if (out_en) begin
              dbg_out   <= mem_q[7:0];
              dbg_valid <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign pc_out = pc;
endmodule

// File: tb/tb_n1_core.sv
// tb_n1_core: scoreboard bench for n1_core against an
// instruction-level reference model.
module tb_n1_core;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        prog_we = 1'b0;
  logic [7:0]  prog_addr = '0;
  logic [15:0] prog_data = '0;
  logic [7:0]  dbg_out;
  logic        dbg_valid;
  logic        halted;
  logic        fault;
  logic [7:0]  pc_out;

  n1_core dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .dbg_out(dbg_out),
    .dbg_valid(dbg_valid), .halted(halted),
    .fault(fault), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [15:0] img [128];
  logic [15:0] mm [128];
  logic [7:0]  exp_q [$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && dbg_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dbg_unexpected act=%0h exp=none",
                 dbg_out);
      end else begin
        chk("dbg_out", {24'd0, dbg_out}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  function automatic logic [15:0] enc(int op, int d, int a, int b);
    return {op[3:0], d[2:0], a[2:0], b[2:0], 3'b000};
  endfunction

  function automatic logic [15:0] enca(int op, int d, int ad);
    return {op[3:0], d[2:0], 1'b0, ad[7:0]};
  endfunction

  // ISA-level model: one loop iteration per instruction
  task automatic model_run(output int cyc, output bit mh,
                           output bit mf, output logic [7:0] mpc);
    logic [15:0] r [8];
    logic [7:0]  stk [$];
    logic [7:0]  pc, npc, ad;
    logic [15:0] w, res;
    bit z, lt, bad;
    int n, o, d, a, b, sa, sb, sd;
    foreach (r[i]) r[i] = '0;
    z = 0; lt = 0; pc = 0; n = 0;
    mh = 0; mf = 0; cyc = 0;
    for (int step = 0; step < 5000; step++) begin
      if (pc >= 8'd128) begin
        mf = 1; cyc = 2 * n + 1; break;
      end
      w = mm[pc[6:0]];
      n++;
      o = w[15:12]; d = w[11:9]; a = w[8:6]; b = w[5:3];
      ad = w[7:0];
      sa = int'($signed(r[a]));
      sb = int'($signed(r[b]));
      sd = int'($signed(r[d]));
      case (o)
        1:       bad = d >= 4;
        2, 6:    bad = d >= 4 || ad >= 128;
        3, 4, 5: bad = d >= 4 || a >= 4 || b >= 4;
        7:       bad = ad >= 128;
        9:       bad = d >= 4 || a >= 4;
        10, 11, 12, 13: bad = ad >= 128;
        14:      bad = ad >= 128 || stk.size() == 8;
        15:      bad = stk.size() == 0;
        default: bad = 0;
      endcase
      if (bad) begin mf = 1; cyc = 2 * n; break; end
      if (o == 8) begin mh = 1; cyc = 2 * n; break; end
      npc = pc + 8'd1;
      case (o)
        1: r[d] = {8'd0, ad};
        2: mm[ad[6:0]] = r[d];
        3: begin
          res = r[a] + r[b];
          z = (res == 0); lt = (sa + sb) < 0; r[d] = res;
        end
        4: begin
          res = r[a] - r[b];
          z = (res == 0); lt = (sa - sb) < 0; r[d] = res;
        end
        5: r[d] = r[a] * r[b];
        6: r[d] = mm[ad[6:0]];
        7: exp_q.push_back(mm[ad[6:0]][7:0]);
        9: begin z = (r[d] == r[a]); lt = (sd - sa) < 0; end
        10: npc = ad;
        11: if (!z) npc = ad;
        12: if (z || lt) npc = ad;
        13: if (z) npc = ad;
        14: begin stk.push_back(pc + 8'd1); npc = ad; end
        15: npc = stk.pop_back();
        default: ;
      endcase
      pc = npc;
    end
    mpc = pc;
  endtask

  task automatic host_wr(input int ad, input logic [15:0] dat);
    @(negedge clk);
    prog_we = 1; prog_addr = ad[7:0]; prog_data = dat;
    @(posedge clk);
  endtask

  // last write shares its cycle with run
  task automatic load_run(input int n, input bit full);
    for (int i = 1; i < n; i++) host_wr(i, img[i]);
    if (full) host_wr(192, 16'hDEAD);
    @(negedge clk);
    prog_we = 1; prog_addr = 0; prog_data = img[0]; run = 1;
    @(posedge clk);
    for (int i = 0; i < n; i++) mm[i] = img[i];
  endtask

  task automatic run_only();
    @(negedge clk);
    run = 1;
    @(posedge clk);
  endtask

  task automatic run_check(input string nm, input bit noise);
    int cyc, ecyc;
    bit eh, ef, done;
    logic [7:0] epc;
    model_run(ecyc, eh, ef, epc);
    #1;
    prog_we = 0; cyc = 0; done = 0;
    while (!done && cyc < 6000) begin
      if (noise) begin
        prog_we = 1; prog_addr = 8'd64; prog_data = 16'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
      if (halted === 1'b1 || fault === 1'b1) done = 1;
    end
    prog_we = 0; run = 0;
    chk({nm, "_done"}, {31'd0, done}, 32'd1);
    chk({nm, "_halted"}, {31'd0, halted}, {31'd0, eh});
    chk({nm, "_fault"}, {31'd0, fault}, {31'd0, ef});
    chk({nm, "_pc"}, {24'd0, pc_out}, {24'd0, epc});
    chk({nm, "_cycles"}, cyc, ecyc);
    repeat (2) @(negedge clk);
    chk({nm, "_outs_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset(input bit check);
    @(negedge clk);
    rst_n = 0; run = 0; prog_we = 0;
    #2;
    if (check) begin
      chk("rst_dbg_out", {24'd0, dbg_out}, 0);
      chk("rst_dbg_valid", {31'd0, dbg_valid}, 0);
      chk("rst_halted", {31'd0, halted}, 0);
      chk("rst_fault", {31'd0, fault}, 0);
      chk("rst_pc", {24'd0, pc_out}, 0);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic clear_img();
    foreach (img[i]) img[i] = '0;
  endtask

  function automatic int rnd_reg();
    if ($urandom_range(0, 39) == 0) return $urandom_range(4, 7);
    return $urandom_range(0, 3);
  endfunction

  task automatic gen_random();
    int len, k, t;
    clear_img();
    for (int i = 64; i < 96; i++) img[i] = 16'($urandom);
    len = $urandom_range(8, 40);
    for (int i = 0; i < len; i++) begin
      k = $urandom_range(0, 11);
      t = $urandom_range(64, 95);
      case (k)
        0: img[i] = enca(1, rnd_reg(), $urandom_range(0, 255));
        1: img[i] = enca(2, rnd_reg(), t);
        2: img[i] = enc(3, rnd_reg(), rnd_reg(), rnd_reg());
        3: img[i] = enc(4, rnd_reg(), rnd_reg(), rnd_reg());
        4: img[i] = enc(5, rnd_reg(), rnd_reg(), rnd_reg());
        5, 11: img[i] = enca(6, rnd_reg(), t);
        6, 7: img[i] = enca(7, 0, t);
        8: img[i] = enc(9, rnd_reg(), rnd_reg(), 0);
        9: begin
          t = $urandom_range(i + 1, len);
          if ($urandom_range(0, 49) == 0) t = 200;
          img[i] = enca($urandom_range(10, 13), 0, t);
        end
        default: img[i] = 16'h0000;
      endcase
    end
    img[len] = enca(8, 0, 0);
  endtask

  task automatic build_calls(input bit overflow);
    clear_img();
    img[0] = enca(14, 0, 10);
    img[1] = enca(7, 0, 50);
    img[2] = enca(8, 0, 0);
    for (int k = 0; k < 7; k++) begin
      img[10 + 2 * k] = enca(14, 0, 12 + 2 * k);
      img[11 + 2 * k] = enc(15, 0, 0, 0);
    end
    img[24] = overflow ? enca(14, 0, 26) : enca(7, 0, 51);
    img[25] = enc(15, 0, 0, 0);
    img[26] = enc(15, 0, 0, 0);
    img[50] = 16'h0011;
    img[51] = 16'h0022;
  endtask

  initial begin
    #2;
    chk("por_dbg_out", {24'd0, dbg_out}, 0);
    chk("por_pc", {24'd0, pc_out}, 0);
    do_reset(1);

    clear_img();
    img[0] = enca(1, 0, 5);
    img[1] = enca(1, 1, 7);
    img[2] = enc(3, 2, 0, 1);
    img[3] = enca(2, 2, 20);
    img[4] = enca(7, 0, 20);
    img[5] = enca(8, 0, 0);
    load_run(128, 1);
    run_check("example", 0);

    do_reset(1);
    run_only();
    run_check("rerun", 0);

    do_reset(0);
    clear_img();
    img[0]  = enca(1, 0, 0);
    img[1]  = enca(1, 1, 1);
    img[2]  = enca(1, 3, 4);
    img[3]  = enc(3, 0, 0, 1);
    img[4]  = enc(9, 0, 3, 0);
    img[5]  = enca(11, 0, 3);
    img[6]  = enca(2, 0, 40);
    img[7]  = enca(7, 0, 40);
    img[8]  = enca(1, 0, 0);
    img[9]  = enc(4, 0, 0, 1);
    img[10] = enca(2, 0, 41);
    img[11] = enca(7, 0, 41);
    img[12] = enc(9, 0, 3, 0);
    img[13] = enca(12, 0, 15);
    img[14] = enca(7, 0, 40);
    img[15] = enca(6, 0, 42);
    img[16] = enc(3, 2, 0, 1);
    img[17] = enca(12, 0, 19);
    img[18] = enca(7, 0, 43);
    img[19] = enca(2, 2, 44);
    img[20] = enca(7, 0, 44);
    img[21] = enca(8, 0, 0);
    img[42] = 16'h7FFF;
    img[43] = 16'h0033;
    load_run(128, 1);
    run_check("loop_flags", 0);

    do_reset(0);
    build_calls(0);
    load_run(128, 1);
    run_check("call8", 0);

    do_reset(0);
    build_calls(1);
    load_run(128, 1);
    run_check("call9", 0);

    do_reset(0);
    clear_img();
    img[0] = enc(15, 0, 0, 0);
    load_run(128, 1);
    run_check("ret_empty", 0);

    do_reset(0);
    clear_img();
    img[0] = enca(7, 0, 10);
    img[1] = enca(6, 0, 200);
    img[10] = 16'h005A;
    load_run(128, 1);
    run_check("ldr_oob", 0);

    do_reset(0);
    clear_img();
    img[0] = enca(1, 4, 9);
    load_run(128, 1);
    run_check("bad_reg", 0);

    do_reset(0);
    clear_img();
    img[0] = enca(10, 0, 130);
    load_run(128, 1);
    run_check("jmp_oob", 0);

    do_reset(0);
    clear_img();
    img[0] = enca(10, 0, 120);
    load_run(128, 1);
    run_check("pc_oob", 0);

    do_reset(0);
    clear_img();
    img[0] = enca(6, 0, 60);
    img[1] = enca(2, 0, 2);
    img[2] = enca(8, 0, 0);
    img[3] = enca(8, 0, 0);
    img[60] = enca(7, 0, 62);
    img[62] = 16'h0099;
    load_run(128, 1);
    run_check("selfmod", 0);

    do_reset(0);
    clear_img();
    img[0] = enca(7, 0, 31);
    img[1] = enca(1, 0, 8'h55);
    img[2] = enca(2, 0, 30);
    img[3] = enca(8, 0, 0);
    img[30] = 16'h00AB;
    img[31] = 16'h0077;
    load_run(128, 1);
    exp_q.push_back(8'h77);
    #1;
    prog_we = 0;
    repeat (5) @(posedge clk);
    #2;
    chk("pre_rst_pc", {24'd0, pc_out}, 2);
    chk("pre_rst_dbg", {24'd0, dbg_out}, 8'h77);
    rst_n = 0; run = 0;
    #1;
    chk("mid_rst_dbg_out", {24'd0, dbg_out}, 0);
    chk("mid_rst_pc", {24'd0, pc_out}, 0);
    chk("mid_rst_valid", {31'd0, dbg_valid}, 0);
    chk("mid_rst_halted", {31'd0, halted}, 0);
    chk("mid_rst_fault", {31'd0, fault}, 0);
    chk("mid_rst_outs_left", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1;
    img[0] = enca(7, 0, 30);
    img[1] = enca(8, 0, 0);
    load_run(2, 0);
    run_check("str_abort", 0);

    for (int t = 0; t < 40; t++) begin
      do_reset(0);
      gen_random();
      load_run(128, 1);
      run_check("rand", t[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
